// File: rtl/approx_adder_pkg.sv
// Shared defaults and types for the lower-part OR approximate adder.
package approx_adder_pkg;

    localparam int WIDTH       = 8;
    localparam int APPROX_BITS = 4;

    typedef logic [WIDTH:0] sum_t;

endpackage

// File: rtl/approx_or_lower.sv
// Approximate low part: bitwise OR of the operand LSBs plus the carry prediction
// into the exact upper part. Optional feature macro: APPROX_CARRY_EN.
module approx_or_lower #(
    parameter int APPROX_BITS = approx_adder_pkg::APPROX_BITS
) (
    input  logic [APPROX_BITS-1:0] a,
    input  logic [APPROX_BITS-1:0] b,
    input  logic                   cin,
    output logic [APPROX_BITS-1:0] low,
    output logic                   c
);

    // OR the low bits; Cin can only set bit 0, never ripple
    always_comb begin
        low    = a | b;
        low[0] = a[0] | b[0] | cin;
    end

    // Carry prediction from the top bit of the approximated part
    always_comb begin
`ifdef APPROX_CARRY_EN
        c = a[APPROX_BITS-1] & b[APPROX_BITS-1];
`else
        c = 1'b0;
`endif
    end

endmodule

// File: rtl/lsb_four_approx_or_adder.sv
// Registered lower-part OR approximate adder: {Cout,S} valid one cycle after operands.
// Optional feature macro: APPROX_CARRY_EN (carry prediction into the upper part).
module lsb_four_approx_or_adder #(
    parameter int WIDTH       = approx_adder_pkg::WIDTH,
    parameter int APPROX_BITS = approx_adder_pkg::APPROX_BITS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] S,
    output logic             Cout
);

    localparam int HI_BITS = WIDTH - APPROX_BITS;

    logic [APPROX_BITS-1:0] low;
    logic                   c;
    logic [HI_BITS:0]       hi_sum;

    approx_or_lower #(
        .APPROX_BITS(APPROX_BITS)
    ) u_lower (
        .a   (A[APPROX_BITS-1:0]),
        .b   (B[APPROX_BITS-1:0]),
        .cin (Cin),
        .low (low),
        .c   (c)
    );

    // Exact ripple add of the upper part, carry-in from the prediction only
    always_comb begin
        hi_sum = {1'b0, A[WIDTH-1:APPROX_BITS]}
               + {1'b0, B[WIDTH-1:APPROX_BITS]}
               + {{HI_BITS{1'b0}}, c};
    end

    // Output registers; result captured every cycle, qualified by out_valid
    always_ff @(posedge clk) begin
        if (rst) begin
            S         <= {WIDTH{1'b0}};
            Cout      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            S         <= {hi_sum[HI_BITS-1:0], low};
            Cout      <= hi_sum[HI_BITS];
            out_valid <= in_valid;
        end
    end

endmodule

// File: tb/tb_lsb_four_approx_or_adder.sv
// Directed and exhaustive checks of the registered lower-part OR adder.
// Expected values follow APPROX_CARRY_EN the same way the design build does.
module tb_lsb_four_approx_or_adder;
    import approx_adder_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] A;
    logic [7:0] B;
    logic       Cin;
    logic       out_valid;
    logic [7:0] S;
    logic       Cout;

    int vectors     = 0;
    int miscompares = 0;

    lsb_four_approx_or_adder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .out_valid (out_valid),
        .S         (S),
        .Cout      (Cout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp_val);
        vectors++;
        if (obs !== exp_val) begin
            miscompares++;
            if (miscompares <= 20)
                $display("FAIL %s: got 0x%03h, expected 0x%03h", tag, obs, exp_val);
        end
    endtask

    // Apply one operand set and step past the capturing edge
    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic cin,
                         input logic v, input logic r);
        A = a; B = b; Cin = cin; in_valid = v; rst = r;
        @(posedge clk);
        #1;
    endtask

    // Reference model written straight from the lower-part OR rules
    function automatic sum_t golden(input logic [7:0] a, input logic [7:0] b, input logic cin);
        int lo, hi, cc;
        lo = (a | b) & 15;
        if (cin) lo = lo | 1;
`ifdef APPROX_CARRY_EN
        cc = (a[3] && b[3]) ? 1 : 0;
`else
        cc = 0;
`endif
        hi = (a >> 4) + (b >> 4) + cc;
        return sum_t'(hi * 16 + lo);
    endfunction

    initial begin
        logic [8:0] e88, eff;
`ifdef APPROX_CARRY_EN
        e88 = 9'h118;
        eff = 9'h1FF;
`else
        e88 = 9'h108;
        eff = 9'h1EF;
`endif
        drive(8'h5A, 8'hA5, 1'b1, 1'b1, 1'b1);
        drive(8'h5A, 8'hA5, 1'b1, 1'b1, 1'b1);
        check("reset_sum",   {Cout, S}, 9'h000);
        check("reset_valid", {8'h00, out_valid}, 9'h000);

        // Directed, hand-computed results
        drive(8'h0F, 8'h01, 1'b0, 1'b1, 1'b0);
        check("or_low_0f_01", {Cout, S}, 9'h00F);
        check("valid_high",   {8'h00, out_valid}, 9'h001);
        drive(8'h88, 8'h88, 1'b0, 1'b1, 1'b0);
        check("carry_88_88", {Cout, S}, e88);
        drive(8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0);
        check("all_ones", {Cout, S}, eff);
        drive(8'h30, 8'h50, 1'b0, 1'b1, 1'b0);
        check("exact_30_50", {Cout, S}, 9'h080);
        drive(8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
        check("cin_only", {Cout, S}, 9'h001);
        drive(8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        check("all_zero", {Cout, S}, 9'h000);
        drive(8'h0E, 8'h00, 1'b1, 1'b0, 1'b0);
        check("cin_bit0",    {Cout, S}, 9'h00F);
        check("valid_low",   {8'h00, out_valid}, 9'h000);

        // Mid-stream reset drops the in-flight result
        drive(8'h12, 8'h34, 1'b0, 1'b1, 1'b0);
        check("pre_reset", {Cout, S}, 9'h046);
        drive(8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1);
        check("mid_reset_sum",   {Cout, S}, 9'h000);
        check("mid_reset_valid", {8'h00, out_valid}, 9'h000);
        drive(8'hF0, 8'h20, 1'b0, 1'b1, 1'b0);
        check("post_reset_sum",   {Cout, S}, 9'h110);
        check("post_reset_valid", {8'h00, out_valid}, 9'h001);

        // Exhaustive A/B sweep at Cin=0
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 256; b++) begin
                drive(8'(a), 8'(b), 1'b0, 1'b1, 1'b0);
                check("sweep", {Cout, S}, golden(8'(a), 8'(b), 1'b0));
            end
        end
        check("sweep_valid", {8'h00, out_valid}, 9'h001);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
